// File: rtl/hdmi_packet_scheduler.sv
// hdmi_packet_scheduler
//   Single-clock HDMI data-island packet scheduler. Audio samples are queued
//   in a small FIFO. On every packet_enable one packet is chosen for the next
//   data-island slot. The order is ACR first, then audio, then the lowest
//   unsent InfoFrame, then null. InfoFrames are sent again once every
//   INFOFRAME_PERIOD fields. Layout 0 carries 2-channel audio and layout 1
//   carries 8-channel audio.
// Ports
//   clk_pixel, reset_n        pixel clock, asynchronous active-low reset
//   audio_valid/ready/word    audio sample input handshake (ch0 in the LSBs)
//   acr_tick                  pulse: an ACR packet is due
//   infoframe_enable          per-slot InfoFrame enable
//   video_field_end           pulse at the end of every field
//   packet_enable             pulse: choose the packet for the next slot
//   packet_type/valid         chosen packet code, 1-cycle update strobe
//   audio_layout/packet_word/present/frame_counter   audio packet payload
//   acr_overrun               sticky: ACR requested while one was pending
module hdmi_packet_scheduler #(
  parameter int AUDIO_CHANNELS   = 2,
  parameter int AUDIO_BIT_WIDTH  = 16,
  parameter int FIFO_DEPTH       = 8,
  parameter int AUDIO_MAX_WAIT   = 4,
  parameter int NUM_INFOFRAMES   = 3,
  parameter logic [NUM_INFOFRAMES*8-1:0] INFOFRAME_TYPES = {8'h84, 8'h82, 8'h83},
  parameter int INFOFRAME_PERIOD = 1
) (
  input  logic                                      clk_pixel,
  input  logic                                      reset_n,
  input  logic                                      audio_valid,
  output logic                                      audio_ready,
  input  logic [AUDIO_CHANNELS*AUDIO_BIT_WIDTH-1:0] audio_sample_word,
  input  logic                                      acr_tick,
  input  logic [NUM_INFOFRAMES-1:0]                 infoframe_enable,
  input  logic                                      video_field_end,
  input  logic                                      packet_enable,
  output logic [7:0]                                packet_type,
  output logic                                      packet_valid,
  output logic                                      audio_layout,
  output logic [191:0]                              audio_packet_word,
  output logic [3:0]                                audio_present,
  output logic [7:0]                                frame_counter,
  output logic                                      acr_overrun
);

  localparam int SW = AUDIO_CHANNELS * 24;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = (AUDIO_MAX_WAIT < 1) ? 1 : $clog2(AUDIO_MAX_WAIT + 1);
  localparam int IW = (NUM_INFOFRAMES > 1) ? $clog2(NUM_INFOFRAMES) : 1;
  localparam logic          LAYOUT_1     = (AUDIO_CHANNELS == 8);
  localparam logic [CW-1:0] DEPTH_C      = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] FOUR_C       = CW'(3'd4);
  localparam logic [WW-1:0] MAX_WAIT_C   = WW'(AUDIO_MAX_WAIT);
  localparam logic [3:0]    LAST_FIELD_C = 4'(INFOFRAME_PERIOD - 1);

  // Samples are stored with every channel left-justified to 24 bits.
  function automatic logic [SW-1:0] left_justify(
    input logic [AUDIO_CHANNELS*AUDIO_BIT_WIDTH-1:0] w);
    logic [SW-1:0] r;
    r = '0;
    for (int c = 0; c < AUDIO_CHANNELS; c++) begin
      r[c*24 +: 24] = 24'(w[c*AUDIO_BIT_WIDTH +: AUDIO_BIT_WIDTH]) << (24 - AUDIO_BIT_WIDTH);
    end
    return r;
  endfunction

  logic [SW-1:0]             mem_q [FIFO_DEPTH];
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic                      ready_q, ready_d;
  logic [WW-1:0]             wait_q, wait_d;
  logic                      acr_pending_q, acr_pending_d;
  logic                      acr_overrun_q, acr_overrun_d;
  logic [NUM_INFOFRAMES-1:0] sent_q, sent_d;
  logic [3:0]                field_q, field_d;
  logic [7:0]                fc_q, fc_d;
  logic [7:0]                type_q, type_d;
  logic                      valid_q, valid_d;
  logic                      layout_q, layout_d;
  logic [191:0]              word_q, word_d;
  logic [3:0]                present_q, present_d;
  logic [7:0]                fc_out_q, fc_out_d;

  logic          push_s, aud_avail_s, acr_sel_s, aud_sel_s, if_sel_s, if_hit_s, field_wrap_s;
  logic [2:0]    pop_n_s;
  logic [IW-1:0] if_idx_s;
  logic [191:0]  pkt_word_s;
  logic [3:0]    pkt_present_s;
  logic [8:0]    fc_sum_s;

  // Audio availability, arbitration and the payload of the candidate packet.
  always_comb begin
    push_s = audio_valid && ready_q;
    if (LAYOUT_1) begin
      aud_avail_s = (count_q != '0);
      pop_n_s     = 3'd1;
    end else if (count_q >= FOUR_C) begin
      aud_avail_s = 1'b1;
      pop_n_s     = 3'd4;
    end else if ((count_q != '0) && (wait_q >= MAX_WAIT_C)) begin
      // A partial group has waited long enough; flush what is there.
      aud_avail_s = 1'b1;
      pop_n_s     = 3'(count_q);
    end else begin
      aud_avail_s = 1'b0;
      pop_n_s     = 3'd0;
    end

    // Scan from the top down so the lowest eligible slot is the last one written.
    if_hit_s = 1'b0;
    if_idx_s = '0;
    for (int i = NUM_INFOFRAMES - 1; i >= 0; i--) begin
      if (!sent_q[i] && infoframe_enable[i]) begin
        if_hit_s = 1'b1;
        if_idx_s = IW'(i);
      end else begin
        if_hit_s = if_hit_s;
      end
    end

    acr_sel_s = packet_enable && acr_pending_q;
    aud_sel_s = packet_enable && !acr_pending_q && aud_avail_s;
    if_sel_s  = packet_enable && !acr_pending_q && !aud_avail_s && if_hit_s;

    pkt_word_s    = '0;
    pkt_present_s = 4'b0000;
    if (LAYOUT_1) begin
      pkt_word_s    = 192'(mem_q[rd_ptr_q]);
      pkt_present_s = 4'b1111;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < pop_n_s) begin
          pkt_word_s[k*48 +: 48] = mem_q[rd_ptr_q + PW'(k)][47:0];
          pkt_present_s[k]       = 1'b1;
        end else begin
          pkt_present_s[k] = 1'b0;
        end
      end
    end

    fc_sum_s = {1'b0, fc_q} + {6'd0, pop_n_s};
  end

  // Next-state logic for FIFO, counters, flags and the registered outputs.
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + PW'(1'b1)) : wr_ptr_q;
    rd_ptr_d = aud_sel_s ? (rd_ptr_q + PW'(pop_n_s)) : rd_ptr_q;
    count_d  = count_q + CW'(push_s) - (aud_sel_s ? CW'(pop_n_s) : CW'(1'b0));
    ready_d  = (count_d != DEPTH_C);
    layout_d = LAYOUT_1;

    if (aud_sel_s || (count_q == '0)) begin
      wait_d = '0;
    end else if (packet_enable && (count_q < FOUR_C) && (wait_q != {WW{1'b1}})) begin
      wait_d = wait_q + WW'(1'b1);
    end else begin
      wait_d = wait_q;
    end

    // A tick arriving with the selection re-arms ACR for the next slot.
    if (acr_sel_s) begin
      acr_pending_d = acr_tick;
    end else begin
      acr_pending_d = acr_pending_q | acr_tick;
    end
    if (acr_tick && acr_pending_q && !acr_sel_s) begin
      acr_overrun_d = 1'b1;
    end else begin
      acr_overrun_d = acr_overrun_q;
    end

    field_wrap_s = video_field_end && (field_q == LAST_FIELD_C);
    if (!video_field_end) begin
      field_d = field_q;
    end else if (field_wrap_s) begin
      field_d = 4'd0;
    end else begin
      field_d = field_q + 4'd1;
    end

    // The period clear overrides a slot picked in the same cycle.
    sent_d = sent_q;
    if (field_wrap_s) begin
      sent_d = '0;
    end else if (if_sel_s) begin
      sent_d[if_idx_s] = 1'b1;
    end else begin
      sent_d = sent_q;
    end

    if (!aud_sel_s) begin
      fc_d = fc_q;
    end else if (fc_sum_s >= 9'd192) begin
      fc_d = 8'(fc_sum_s - 9'd192);
    end else begin
      fc_d = fc_sum_s[7:0];
    end

    valid_d   = packet_enable;
    type_d    = type_q;
    word_d    = word_q;
    present_d = present_q;
    fc_out_d  = fc_out_q;
    if (packet_enable) begin
      fc_out_d  = fc_q;
      word_d    = '0;
      present_d = 4'b0000;
      if (acr_sel_s) begin
        type_d = 8'h01;
      end else if (aud_sel_s) begin
        type_d    = 8'h02;
        word_d    = pkt_word_s;
        present_d = pkt_present_s;
      end else if (if_sel_s) begin
        type_d = INFOFRAME_TYPES[(NUM_INFOFRAMES - 1 - int'(if_idx_s))*8 +: 8];
      end else begin
        type_d = 8'h00;
      end
    end else begin
      type_d = type_q;
    end
  end

  // Sample storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_pixel) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= left_justify(audio_sample_word);
    end
  end

  // State and output registers.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      ready_q       <= 1'b1;
      wait_q        <= '0;
      acr_pending_q <= 1'b0;
      acr_overrun_q <= 1'b0;
      sent_q        <= '0;
      field_q       <= 4'd0;
      fc_q          <= 8'd0;
      type_q        <= 8'h00;
      valid_q       <= 1'b0;
      layout_q      <= LAYOUT_1;
      word_q        <= '0;
      present_q     <= 4'b0000;
      fc_out_q      <= 8'd0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      ready_q       <= ready_d;
      wait_q        <= wait_d;
      acr_pending_q <= acr_pending_d;
      acr_overrun_q <= acr_overrun_d;
      sent_q        <= sent_d;
      field_q       <= field_d;
      fc_q          <= fc_d;
      type_q        <= type_d;
      valid_q       <= valid_d;
      layout_q      <= layout_d;
      word_q        <= word_d;
      present_q     <= present_d;
      fc_out_q      <= fc_out_d;
    end
  end

  assign audio_ready       = ready_q;
  assign packet_type       = type_q;
  assign packet_valid      = valid_q;
  assign audio_layout      = layout_q;
  assign audio_packet_word = word_q;
  assign audio_present     = present_q;
  assign frame_counter     = fc_out_q;
  assign acr_overrun       = acr_overrun_q;

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// tb_hdmi_packet_scheduler
//   Scoreboard bench for hdmi_packet_scheduler (2-ch layout, InfoFrame period 2).
//   Each packet_enable pushes the expected packet onto a queue. A monitor on
//   the falling edge pops that entry and compares it whenever packet_valid is seen.
module tb_hdmi_packet_scheduler;

  logic         clk_pixel = 1'b0;
  logic         reset_n = 1'b0;
  logic         audio_valid = 1'b0;
  logic         audio_ready;
  logic [31:0]  audio_sample_word = 32'd0;
  logic         acr_tick = 1'b0;
  logic [2:0]   infoframe_enable = 3'b000;
  logic         video_field_end = 1'b0;
  logic         packet_enable = 1'b0;
  logic [7:0]   packet_type;
  logic         packet_valid;
  logic         audio_layout;
  logic [191:0] audio_packet_word;
  logic [3:0]   audio_present;
  logic [7:0]   frame_counter;
  logic         acr_overrun;

  hdmi_packet_scheduler #(.INFOFRAME_PERIOD(2)) dut (
    .clk_pixel(clk_pixel), .reset_n(reset_n),
    .audio_valid(audio_valid), .audio_ready(audio_ready), .audio_sample_word(audio_sample_word),
    .acr_tick(acr_tick), .infoframe_enable(infoframe_enable), .video_field_end(video_field_end),
    .packet_enable(packet_enable), .packet_type(packet_type), .packet_valid(packet_valid),
    .audio_layout(audio_layout), .audio_packet_word(audio_packet_word),
    .audio_present(audio_present), .frame_counter(frame_counter), .acr_overrun(acr_overrun)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    logic [7:0]   ptype;
    logic [3:0]   present;
    logic [191:0] word;
    logic [7:0]   fc;
    bit           is_audio;
    bit           is_null;
  } exp_t;

  exp_t        exp_q[$];
  logic [47:0] smp_q[$];
  int          fc_m = 0;
  int          seq = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        mon_e;

  task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_pixel);
    #1;
  endtask

  function automatic exp_t mk(input logic [7:0] t, input bit nul);
    exp_t e;
    e.ptype = t; e.present = 4'b0000; e.word = '0; e.fc = 8'd0;
    e.is_audio = 1'b0; e.is_null = nul;
    return e;
  endfunction

  task automatic push_sample();
    logic [15:0] c0, c1;
    c0 = 16'h1234 + 16'(seq);
    c1 = 16'hABCD - 16'(seq);
    seq++;
    audio_valid = 1'b1;
    audio_sample_word = {c1, c0};
    if (audio_ready) smp_q.push_back({c1, 8'h00, c0, 8'h00});
    step();
    audio_valid = 1'b0;
  endtask

  task automatic fire(input exp_t e, input bit tick, input bit fe);
    exp_q.push_back(e);
    packet_enable = 1'b1;
    acr_tick = tick;
    video_field_end = fe;
    step();
    packet_enable = 1'b0;
    acr_tick = 1'b0;
    video_field_end = 1'b0;
  endtask

  task automatic fire_audio(input int n);
    exp_t e;
    e = mk(8'h02, 1'b0);
    e.is_audio = 1'b1;
    for (int k = 0; k < n; k++) e.word[k*48 +: 48] = smp_q.pop_front();
    e.present = 4'((1 << n) - 1);
    e.fc = 8'(fc_m);
    fc_m = (fc_m + n) % 192;
    fire(e, 1'b0, 1'b0);
  endtask

  task automatic field_end();
    video_field_end = 1'b1;
    step();
    video_field_end = 1'b0;
  endtask

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge clk_pixel) begin
    if (reset_n && packet_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid", 192'(packet_valid), 192'(1'b0));
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("ptype", 192'(packet_type), 192'(mon_e.ptype));
        if (mon_e.is_audio) begin
          check_eq("present", 192'(audio_present), 192'(mon_e.present));
          check_eq("word", audio_packet_word, mon_e.word);
          check_eq("frame_counter", 192'(frame_counter), 192'(mon_e.fc));
        end else if (mon_e.is_null) begin
          check_eq("null_present", 192'(audio_present), 192'(4'b0000));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d expected packets outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pre_fc;
    bit         wrap_next;
    wrap_next = 1'b0;

    // Reset state
    repeat (3) step();
    check_eq("rst_ready", 192'(audio_ready), 192'(1'b1));
    check_eq("rst_type", 192'(packet_type), 192'(8'h00));
    check_eq("rst_valid", 192'(packet_valid), 192'(1'b0));
    check_eq("rst_layout", 192'(audio_layout), 192'(1'b0));
    check_eq("rst_present", 192'(audio_present), 192'(4'b0000));
    check_eq("rst_fc", 192'(frame_counter), 192'(8'd0));
    check_eq("rst_overrun", 192'(acr_overrun), 192'(1'b0));
    reset_n = 1'b1;
    step();

    // T2: four 16-bit samples form one full layout-0 packet
    repeat (4) push_sample();
    fire_audio(4);
    check_eq("t2_sp0w0", 192'(audio_packet_word[23:0]), 192'(24'h123400));
    check_eq("t2_fc0", 192'(frame_counter), 192'(8'd0));
    repeat (4) push_sample();
    fire_audio(4);
    check_eq("t2_fc4", 192'(frame_counter), 192'(8'd4));

    // T3: ACR beats queued audio; a second tick while pending is an overrun
    acr_tick = 1'b1; step(); acr_tick = 1'b0;
    repeat (4) push_sample();
    fire(mk(8'h01, 1'b0), 1'b0, 1'b0);
    fire_audio(4);
    acr_tick = 1'b1; step(); acr_tick = 1'b0;
    check_eq("t3_no_overrun", 192'(acr_overrun), 192'(1'b0));
    acr_tick = 1'b1; step(); acr_tick = 1'b0;
    check_eq("t3_overrun", 192'(acr_overrun), 192'(1'b1));
    fire(mk(8'h01, 1'b0), 1'b1, 1'b0);
    fire(mk(8'h01, 1'b0), 1'b0, 1'b0);
    fire(mk(8'h00, 1'b1), 1'b0, 1'b0);

    // T4: a lone sample goes out partially after AUDIO_MAX_WAIT slots
    push_sample();
    repeat (4) fire(mk(8'h00, 1'b1), 1'b0, 1'b0);
    fire_audio(1);
    check_eq("t4_present", 192'(audio_present), 192'(4'b0001));

    // T5: InfoFrame rounds with a period of two fields
    infoframe_enable = 3'b101;
    fire(mk(8'h84, 1'b0), 1'b0, 1'b0);
    fire(mk(8'h83, 1'b0), 1'b0, 1'b0);
    fire(mk(8'h00, 1'b1), 1'b0, 1'b0);
    field_end();
    fire(mk(8'h00, 1'b1), 1'b0, 1'b0);
    field_end();
    fire(mk(8'h84, 1'b0), 1'b0, 1'b0);
    field_end();
    fire(mk(8'h83, 1'b0), 1'b0, 1'b1);
    fire(mk(8'h84, 1'b0), 1'b0, 1'b0);
    fire(mk(8'h83, 1'b0), 1'b0, 1'b0);
    fire(mk(8'h00, 1'b1), 1'b0, 1'b0);
    infoframe_enable = 3'b000;

    // T1: asynchronous reset in the middle of a stream
    repeat (3) push_sample();
    acr_tick = 1'b1; step(); acr_tick = 1'b0;
    #2;
    reset_n = 1'b0;
    packet_enable = 1'b1;
    #1;
    check_eq("t1_ready", 192'(audio_ready), 192'(1'b1));
    check_eq("t1_type", 192'(packet_type), 192'(8'h00));
    check_eq("t1_valid", 192'(packet_valid), 192'(1'b0));
    check_eq("t1_overrun", 192'(acr_overrun), 192'(1'b0));
    repeat (2) begin
      @(negedge clk_pixel);
      check_eq("t1_valid_in_reset", 192'(packet_valid), 192'(1'b0));
    end
    step();
    packet_enable = 1'b0;
    exp_q.delete();
    smp_q.delete();
    fc_m = 0;
    reset_n = 1'b1;
    step();

    // T6: fill the FIFO, refuse the extra sample, then wrap the frame counter
    repeat (7) push_sample();
    check_eq("t6_ready_7", 192'(audio_ready), 192'(1'b1));
    push_sample();
    check_eq("t6_ready_full", 192'(audio_ready), 192'(1'b0));
    audio_valid = 1'b1;
    audio_sample_word = 32'hDEAD_BEEF;
    repeat (3) step();
    audio_valid = 1'b0;
    check_eq("t6_still_full", 192'(audio_ready), 192'(1'b0));
    fire_audio(4);
    fire_audio(4);
    for (int i = 0; i < 48; i++) begin
      repeat (4) push_sample();
      pre_fc = 8'(fc_m);
      fire_audio(4);
      if (wrap_next) begin
        check_eq("t6_fc_wrap", 192'(frame_counter), 192'(8'd0));
        wrap_next = 1'b0;
      end
      if (pre_fc == 8'd188) wrap_next = 1'b1;
    end

    @(negedge clk_pixel);
    #1;
    check_eq("queue_drained", 192'(exp_q.size()), 192'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
